// File: rtl/tb_ram_pkg.sv
// Shared definitions for the RAM fill/check test stages: size defaults,
// AXI encodings, and the FSM state types.
package tb_ram_pkg;

    localparam int DEF_RAM_SIZE   = 65536;
    localparam int DEF_BLOCK_SIZE = 4096;

    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam logic [1:0] RESP_OKAY  = 2'd0;

    typedef enum logic {
        AR_IDLE,
        AR_ISSUE
    } ar_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RECV,
        R_DRAIN
    } r_state_e;

    typedef struct packed {
        ar_state_e ar_state;
        r_state_e  r_state;
        logic      bad_beat;
    } check_ram_dbg_t;

endpackage

// File: rtl/check_ram_cmp.sv
// Registered compare stage: flags beats that break the fill pattern and keeps
// the saturating error count; first-error capture exists with CHECK_RAM_FIRST_ERR_EN.
module check_ram_cmp
    import tb_ram_pkg::*;
#(
    parameter int          DW         = 512,
    parameter int          AW         = 16,
    parameter int          NW         = 10,
    parameter int          BPB        = 64,
    parameter logic [31:0] FIRST_DATA = 32'hC000_0000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          beat_valid,
    input  logic [NW-1:0] n,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp,
    input  logic          rlast,
`ifdef CHECK_RAM_FIRST_ERR_EN
    output logic          first_err_valid,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data,
`endif
    output logic          bad_beat,
    output logic [31:0]   error_count
);

    logic [DW-1:0] exp_data;
    logic          exp_last;
    logic          bad;
    logic          bad_q, bad_d;
    logic [31:0]   err_cnt_q, err_cnt_d;

    // Any number of failing conditions on one beat still counts as one error.
    always_comb begin
        exp_data  = DW'(FIRST_DATA) + DW'(n);
        exp_last  = ((32'(n) % 32'(BPB)) == 32'(BPB - 1));
        bad       = beat_valid && ((rdata != exp_data) || (rresp != RESP_OKAY) || (rlast != exp_last));
        bad_d     = bad;
        err_cnt_d = err_cnt_q;
        if (clear) begin
            err_cnt_d = '0;
        end else if (bad && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bad_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            bad_q     <= bad_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bad_beat    = bad_q;
    assign error_count = err_cnt_q;

`ifdef CHECK_RAM_FIRST_ERR_EN
    localparam int BYTES = DW / 8;

    logic          fe_valid_q, fe_valid_d;
    logic [AW-1:0] fe_addr_q, fe_addr_d;
    logic [DW-1:0] fe_data_q, fe_data_d;

    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_addr_d  = fe_addr_q;
        fe_data_d  = fe_data_q;
        if (clear) begin
            fe_valid_d = 1'b0;
            fe_addr_d  = '0;
            fe_data_d  = '0;
        end else if (bad && !fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_addr_d  = AW'(32'(n) * 32'(BYTES));
            fe_data_d  = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fe_valid_q <= 1'b0;
            fe_addr_q  <= '0;
            fe_data_q  <= '0;
        end else begin
            fe_valid_q <= fe_valid_d;
            fe_addr_q  <= fe_addr_d;
            fe_data_q  <= fe_data_d;
        end
    end

    assign first_err_valid = fe_valid_q;
    assign first_err_addr  = fe_addr_q;
    assign first_err_data  = fe_data_q;
`endif

endmodule

// File: rtl/check_ram.sv
// RAM read-back checker: issues one INCR burst per block and verifies the incrementing
// fill pattern. Define CHECK_RAM_FIRST_ERR_EN to add the first-error capture outputs.
module check_ram
    import tb_ram_pkg::*;
#(
    parameter int          DW         = 512,
    parameter int          AW         = 16,
    parameter logic [31:0] FIRST_DATA = 32'hC000_0000,
    parameter int          RAM_SIZE   = DEF_RAM_SIZE,
    parameter int          BLOCK_SIZE = DEF_BLOCK_SIZE
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [31:0]    error_count,
`ifdef CHECK_RAM_FIRST_ERR_EN
    output logic           first_err_valid,
    output logic [AW-1:0]  first_err_addr,
    output logic [DW-1:0]  first_err_data,
`endif
    output check_ram_dbg_t dbg_state,
    output logic [AW-1:0]  M_AXI_ARADDR,
    output logic           M_AXI_ARVALID,
    input  logic           M_AXI_ARREADY,
    output logic [7:0]     M_AXI_ARLEN,
    output logic [2:0]     M_AXI_ARSIZE,
    output logic [1:0]     M_AXI_ARBURST,
    output logic [3:0]     M_AXI_ARID,
    output logic [3:0]     M_AXI_ARCACHE,
    output logic [3:0]     M_AXI_ARQOS,
    output logic [2:0]     M_AXI_ARPROT,
    output logic           M_AXI_ARLOCK,
    input  logic [DW-1:0]  M_AXI_RDATA,
    input  logic [1:0]     M_AXI_RRESP,
    input  logic           M_AXI_RLAST,
    input  logic           M_AXI_RVALID,
    output logic           M_AXI_RREADY
);

    localparam int BYTES       = DW / 8;
    localparam int BPB         = BLOCK_SIZE / BYTES;
    localparam int MAX_BLOCKS  = RAM_SIZE / BLOCK_SIZE;
    localparam int TOTAL_BEATS = MAX_BLOCKS * BPB;
    localparam int NW          = (TOTAL_BEATS > 1) ? $clog2(TOTAL_BEATS) : 1;
    localparam int BW          = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

    ar_state_e     ar_state_q, ar_state_d;
    r_state_e      r_state_q, r_state_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [NW-1:0] n_q, n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          start_acc;
    logic          r_hs;
    logic          bad_beat;

    // AR and R sides run independently; addresses may run ahead of data.
    always_comb begin
        start_acc  = start && !busy_q;
        r_hs       = (r_state_q == R_RECV) && M_AXI_RVALID;
        ar_state_d = ar_state_q;
        r_state_d  = r_state_q;
        blk_d      = blk_q;
        araddr_d   = araddr_q;
        n_d        = n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;

        case (ar_state_q)
            AR_IDLE: if (start_acc) begin
                ar_state_d = AR_ISSUE;
                blk_d      = '0;
                araddr_d   = '0;
            end
            AR_ISSUE: if (M_AXI_ARREADY) begin
                blk_d    = blk_q + 1'b1;
                araddr_d = araddr_q + AW'(BLOCK_SIZE);
                if (blk_q == BW'(MAX_BLOCKS - 1)) ar_state_d = AR_IDLE;
            end
            default: ar_state_d = AR_IDLE;
        endcase

        // DRAIN gives the compare stage one cycle to fold in the last beat.
        case (r_state_q)
            R_IDLE: if (start_acc) begin
                r_state_d = R_RECV;
                n_d       = '0;
            end
            R_RECV: if (r_hs) begin
                n_d = n_q + 1'b1;
                if (n_q == NW'(TOTAL_BEATS - 1)) r_state_d = R_DRAIN;
            end
            R_DRAIN: begin
                done_d    = 1'b1;
                pass_d    = (error_count == 32'd0);
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase

        if (start_acc) begin
            busy_d = 1'b1;
            pass_d = 1'b0;
        end else if (done_q) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state_q <= AR_IDLE;
            r_state_q  <= R_IDLE;
            blk_q      <= '0;
            araddr_q   <= '0;
            n_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            ar_state_q <= ar_state_d;
            r_state_q  <= r_state_d;
            blk_q      <= blk_d;
            araddr_q   <= araddr_d;
            n_q        <= n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    check_ram_cmp #(
        .DW         (DW),
        .AW         (AW),
        .NW         (NW),
        .BPB        (BPB),
        .FIRST_DATA (FIRST_DATA)
    ) u_cmp (
        .clk             (clk),
        .resetn          (resetn),
        .clear           (start_acc),
        .beat_valid      (r_hs),
        .n               (n_q),
        .rdata           (M_AXI_RDATA),
        .rresp           (M_AXI_RRESP),
        .rlast           (M_AXI_RLAST),
`ifdef CHECK_RAM_FIRST_ERR_EN
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_data  (first_err_data),
`endif
        .bad_beat        (bad_beat),
        .error_count     (error_count)
    );

    always_comb begin
        dbg_state          = '0;
        dbg_state.ar_state = ar_state_q;
        dbg_state.r_state  = r_state_q;
        dbg_state.bad_beat = bad_beat;
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = (ar_state_q == AR_ISSUE);
    assign M_AXI_RREADY  = (r_state_q == R_RECV);
    assign M_AXI_ARLEN   = 8'(BPB - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARLOCK  = 1'b0;

endmodule
